// File: rtl/mvau_stream_inp_buf.sv
// -----------------------------------------------------------------------------
// mvau_stream_inp_buf
//
// Activation input buffer for the MVAU streaming compute datapath.
//   * FILL   (nf_cnt == 0): each accepted upstream word is written into the
//     vector buffer and forwarded to the output register in the same cycle.
//   * REPLAY (nf_cnt  > 0): the stored vector is read back for the remaining
//     NF-1 filter-bank passes. Upstream is held off (in_rdy = 0).
// Each output word carries two accumulator-clear tags taken from the counters
// that produced it: out_sf_clr marks the last word of a vector and out_nf_clr
// marks the last pass.
//
// Ports
//   clk         clock
//   rst         synchronous reset, active-high
//   in_v        upstream word valid
//   in_rdy      block accepts upstream word
//   in_dat      upstream activation word (SIMD*TI bits)
//   out_v       output word valid
//   out_rdy     downstream accepts output word
//   out_dat     activation word to compute (SIMD*TI bits)
//   out_sf_clr  out_dat is the last word of its vector (sf = SF-1)
//   out_nf_clr  out_dat belongs to the last pass (nf = NF-1)
//   vec_cnt     16-bit count of completed vectors; present only when the
//               macro INP_BUF_VEC_CNT_EN is defined
// -----------------------------------------------------------------------------
module mvau_stream_inp_buf #(
  parameter int SF   = 8,
  parameter int NF   = 2,
  parameter int SIMD = 2,
  parameter int TI   = 4,
  parameter int SF_T = (SF > 1) ? $clog2(SF) : 1,
  parameter int NF_T = (NF > 1) ? $clog2(NF) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_v,
  output logic                 in_rdy,
  input  logic [SIMD*TI-1:0]   in_dat,
  output logic                 out_v,
  input  logic                 out_rdy,
  output logic [SIMD*TI-1:0]   out_dat,
  output logic                 out_sf_clr,
  output logic                 out_nf_clr
`ifdef INP_BUF_VEC_CNT_EN
  ,
  output logic [15:0]          vec_cnt
`endif
);

  localparam int              W       = SIMD * TI;
  localparam logic [SF_T-1:0] SF_LAST = SF_T'(SF - 1);
  localparam logic [NF_T-1:0] NF_LAST = NF_T'(NF - 1);

  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [SF_T-1:0] sf_cnt, sf_nxt;
  logic [NF_T-1:0] nf_cnt, nf_nxt;

  logic            ld;     // output register may take a new word this cycle
  logic            adv;    // a word is loaded into the output register
  logic            wr_en;  // store the accepted upstream word

  // Depth rounded up to a power of two so any sf_cnt value is a legal index.
  logic [W-1:0]    mem [0:(1<<SF_T)-1];

  assign ld = !out_v || out_rdy;

  // ---------------------------------------------------------------------------
  // Next-state / handshake logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    in_rdy    = 1'b0;
    adv       = 1'b0;
    wr_en     = 1'b0;
    state_nxt = state;
    sf_nxt    = sf_cnt;
    nf_nxt    = nf_cnt;

    unique case (state)
      FILL: begin
        in_rdy = ld;
        if (in_v && ld) begin
          adv   = 1'b1;
          wr_en = 1'b1;
        end
      end
      REPLAY: begin
        adv = ld;
      end
      default: ;
    endcase

    // The state is fully determined by nf_cnt: FILL exactly when nf_cnt == 0.
    if (adv) begin
      if (sf_cnt == SF_LAST) begin
        sf_nxt = '0;
        if (nf_cnt == NF_LAST) begin
          nf_nxt    = '0;
          state_nxt = FILL;
        end else begin
          nf_nxt    = nf_cnt + NF_T'(1);
          state_nxt = REPLAY;
        end
      end else begin
        sf_nxt = sf_cnt + SF_T'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state  <= FILL;
      sf_cnt <= '0;
      nf_cnt <= '0;
    end else begin
      state  <= state_nxt;
      sf_cnt <= sf_nxt;
      nf_cnt <= nf_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Vector buffer. The last fill write (addr SF-1) and the first replay read
  // (addr 0) land in different cycles, so no read-during-write case arises.
  // ---------------------------------------------------------------------------
  // NOTE: the buffer has no reset; its contents are always written during FILL
  // before any REPLAY reads them, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[sf_cnt] <= in_dat;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: holds while out_v && !out_rdy; tags follow the counters
  // that selected the word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v      <= 1'b0;
      out_dat    <= '0;
      out_sf_clr <= 1'b0;
      out_nf_clr <= 1'b0;
    end else if (ld) begin
      out_v <= adv;
      if (adv) begin
        out_dat    <= (state == FILL) ? in_dat : mem[sf_cnt];
        out_sf_clr <= (sf_cnt == SF_LAST);
        out_nf_clr <= (nf_cnt == NF_LAST);
      end
    end
  end

`ifdef INP_BUF_VEC_CNT_EN
  // Completed-vector counter: a vector is done once its final word (both tags
  // set) is taken downstream. Wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_cnt <= '0;
    end else if (out_v && out_rdy && out_sf_clr && out_nf_clr) begin
      vec_cnt <= vec_cnt + 16'd1;
    end
  end
`endif

endmodule
